hex_display_monitor: RTL and testbench

- Receive-side checker for the two-digit seven-segment interface driven by the 8-bit up-counter (HEX1 = high nibble, HEX0 = low nibble).
- Decodes both active-low segment patterns back to an 8-bit value and flags patterns that are not legal digits.
- Tracks the counter sequence: each new sample must equal the previous value, the previous value + 1 (mod 256), or 0x00 after a clear. Counts violations.
- Used as an on-chip self-test and bench monitor alongside the counter.

---
 rtl/hex_display_monitor_pkg.sv | 29 ++
 rtl/seg7_to_nibble.sv | 35 +++
 rtl/hex_display_monitor.sv | 146 ++++++++++++++
 tb/tb_hex_display_monitor.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/hex_display_monitor_pkg.sv
// Shared definitions for the seven-segment counter monitor: segment codes
// (active-low, bit0=a .. bit6=g) and the checker FSM state encoding.
package hex_mon_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        ERROR = 2'd2
    } mon_state_t;

endpackage

// File: rtl/seg7_to_nibble.sv
// Inverse seven-segment decoder: maps an active-low segment pattern to its
// hex digit and flags any pattern that is not one of the sixteen digits.
module seg7_to_nibble
    import hex_mon_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_digit,
    output logic       o_legal
);

    always_comb begin
        o_digit = 4'h0;
        o_legal = 1'b1;
        case (i_seg)
            SEG_0:   o_digit = 4'h0;
            SEG_1:   o_digit = 4'h1;
            SEG_2:   o_digit = 4'h2;
            SEG_3:   o_digit = 4'h3;
            SEG_4:   o_digit = 4'h4;
            SEG_5:   o_digit = 4'h5;
            SEG_6:   o_digit = 4'h6;
            SEG_7:   o_digit = 4'h7;
            SEG_8:   o_digit = 4'h8;
            SEG_9:   o_digit = 4'h9;
            SEG_A:   o_digit = 4'hA;
            SEG_B:   o_digit = 4'hB;
            SEG_C:   o_digit = 4'hC;
            SEG_D:   o_digit = 4'hD;
            SEG_E:   o_digit = 4'hE;
            SEG_F:   o_digit = 4'hF;
            default: o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/hex_display_monitor.sv
// Receive-side checker for the two-digit counter display: decodes HEX1/HEX0,
// tracks the count sequence and counts faults. Optional macro HEX_MON_BLANK_EN.
module hex_display_monitor
    import hex_mon_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ERR_W       = 8
) (
    input  logic             Clock,
    input  logic             clear_b,
    input  logic [6:0]       HEX0,
    input  logic [6:0]       HEX1,
    input  logic             sample,
    input  logic             err_ack,
    output logic [7:0]       value,
    output logic             valid,
    output logic             illegal,
    output logic             seq_err,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       state
);

    logic [6:0]       r_hex0_sync [SYNC_STAGES];
    logic [6:0]       r_hex1_sync [SYNC_STAGES];
    logic             r_samp_sync [SYNC_STAGES];

    logic [7:0]       r_value;
    logic             r_valid;
    logic             r_illegal;
    logic             r_seq_err;
    logic [ERR_W-1:0] r_err_count;
    mon_state_t       r_state;

    logic [6:0]       w_hex0;
    logic [6:0]       w_hex1;
    logic             w_sample;
    logic [3:0]       w_digit0;
    logic [3:0]       w_digit1;
    logic             w_legal0;
    logic             w_legal1;
    logic             w_legal;
    logic             w_blank;
    logic [7:0]       w_value;
    logic             w_in_seq;
    logic             w_err_sat;
    logic [ERR_W-1:0] w_err_next;

    // Segment buses and the strobe share one chain so they stay aligned.
    always_ff @(posedge Clock or negedge clear_b) begin
        if (!clear_b) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_hex0_sync[i] <= '0;
                r_hex1_sync[i] <= '0;
                r_samp_sync[i] <= 1'b0;
            end
        end else begin
            r_hex0_sync[0] <= HEX0;
            r_hex1_sync[0] <= HEX1;
            r_samp_sync[0] <= sample;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_hex0_sync[i] <= r_hex0_sync[i-1];
                r_hex1_sync[i] <= r_hex1_sync[i-1];
                r_samp_sync[i] <= r_samp_sync[i-1];
            end
        end
    end

    assign w_hex0   = r_hex0_sync[SYNC_STAGES-1];
    assign w_hex1   = r_hex1_sync[SYNC_STAGES-1];
    assign w_sample = r_samp_sync[SYNC_STAGES-1];

    seg7_to_nibble u_dec_lo (
        .i_seg   (w_hex0),
        .o_digit (w_digit0),
        .o_legal (w_legal0)
    );

    seg7_to_nibble u_dec_hi (
        .i_seg   (w_hex1),
        .o_digit (w_digit1),
        .o_legal (w_legal1)
    );

    assign w_value = {w_digit1, w_digit0};
    assign w_legal = w_legal0 & w_legal1;

`ifdef HEX_MON_BLANK_EN
    assign w_blank = (w_hex0 == SEG_BLANK) && (w_hex1 == SEG_BLANK);
`else
    assign w_blank = 1'b0;
`endif

    // Hold, +1 (8-bit wrap) and clear-to-zero are the counter's only moves.
    assign w_in_seq   = (w_value == r_value) || (w_value == r_value + 8'd1) ||
                        (w_value == 8'h00);
    assign w_err_sat  = &r_err_count;
    assign w_err_next = r_err_count + {{(ERR_W-1){1'b0}}, 1'b1};

    always_ff @(posedge Clock or negedge clear_b) begin
        if (!clear_b) begin
            r_value     <= 8'h00;
            r_valid     <= 1'b0;
            r_illegal   <= 1'b0;
            r_seq_err   <= 1'b0;
            r_err_count <= '0;
            r_state     <= IDLE;
        end else begin
            r_valid <= 1'b0;
            if (w_sample && !w_blank) begin
                if (!w_legal) begin
                    r_illegal <= 1'b1;
                    r_state   <= ERROR;
                    if (!w_err_sat) r_err_count <= w_err_next;
                end else begin
                    r_value <= w_value;
                    r_valid <= 1'b1;
                    case (r_state)
                        IDLE: r_state <= TRACK;
                        TRACK: begin
                            if (!w_in_seq) begin
                                r_seq_err <= 1'b1;
                                r_state   <= ERROR;
                                if (!w_err_sat) r_err_count <= w_err_next;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            // Acknowledge overrides whatever the same-cycle sample decided.
            if (err_ack && (r_state == ERROR)) begin
                r_illegal <= 1'b0;
                r_seq_err <= 1'b0;
                r_state   <= IDLE;
            end
        end
    end

    assign value     = r_value;
    assign valid     = r_valid;
    assign illegal   = r_illegal;
    assign seq_err   = r_seq_err;
    assign err_count = r_err_count;
    assign state     = r_state;

endmodule

// File: tb/tb_hex_display_monitor.sv
// Bench for hex_display_monitor: table of samples/acks with hand-derived
// expectations, plus sequences for ack priority, saturation, async clear, blank.
module tb_hex_display_monitor;

    localparam int SYNC  = 2;
    localparam int ERR_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [6:0]       hex0 = 7'h40;
    logic [6:0]       hex1 = 7'h40;
    logic             sample = 1'b0;
    logic             err_ack = 1'b0;
    logic [7:0]       value;
    logic             valid;
    logic             illegal;
    logic             seq_err;
    logic [ERR_W-1:0] err_count;
    logic [1:0]       state;

    hex_display_monitor #(.SYNC_STAGES(SYNC), .ERR_W(ERR_W)) dut (
        .Clock     (clk),
        .clear_b   (rst_n),
        .HEX0      (hex0),
        .HEX1      (hex1),
        .sample    (sample),
        .err_ack   (err_ack),
        .value     (value),
        .valid     (valid),
        .illegal   (illegal),
        .seq_err   (seq_err),
        .err_count (err_count),
        .state     (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] val;
        logic       vld;
        logic       ill;
        logic       seq;
        logic [7:0] cnt;
        logic [1:0] st;
    } exp_t;

    typedef struct {
        bit         is_ack;
        logic [6:0] h1;
        logic [6:0] h0;
        exp_t       e;
    } vec_t;

    logic [20:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    function automatic exp_t mk(input logic [7:0] v, input logic vl, input logic il,
                                input logic sq, input logic [7:0] c, input logic [1:0] s);
        exp_t e;
        e.val = v; e.vld = vl; e.ill = il; e.seq = sq; e.cnt = c; e.st = s;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic check_out(input string name);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: no expected entry queued", name);
            return;
        end
        e = exp_q.pop_front();
        chk({name, ".value"},     32'(value),     32'(e.val));
        chk({name, ".valid"},     32'(valid),     32'(e.vld));
        chk({name, ".illegal"},   32'(illegal),   32'(e.ill));
        chk({name, ".seq_err"},   32'(seq_err),   32'(e.seq));
        chk({name, ".err_count"}, 32'(err_count), 32'(e.cnt));
        chk({name, ".state"},     32'(state),     32'(e.st));
    endtask

    // One-cycle sample; result is due SYNC+1 clocks later.
    task automatic do_sample(input string name, input logic [6:0] h1, input logic [6:0] h0,
                             input exp_t e);
        exp_q.push_back(e);
        @(negedge clk);
        hex1 = h1; hex0 = h0; sample = 1'b1;
        @(negedge clk);
        sample = 1'b0;
        repeat (SYNC - 1) @(negedge clk);
        chk({name, ".early"}, 32'(valid), 32'd0);
        @(negedge clk);
        check_out(name);
        if (e.vld) begin
            @(negedge clk);
            chk({name, ".pulse"}, 32'(valid), 32'd0);
        end
    endtask

    task automatic do_ack(input string name, input exp_t e);
        exp_q.push_back(e);
        @(negedge clk);
        err_ack = 1'b1;
        @(negedge clk);
        err_ack = 1'b0;
        check_out(name);
    endtask

    vec_t vecs[$];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back('{0, 7'h40, 7'h40, mk(8'h00, 1, 0, 0, 8'd0, 2'd1)});
        vecs.push_back('{0, 7'h40, 7'h79, mk(8'h01, 1, 0, 0, 8'd0, 2'd1)});
        vecs.push_back('{0, 7'h40, 7'h24, mk(8'h02, 1, 0, 0, 8'd0, 2'd1)});
        vecs.push_back('{0, 7'h40, 7'h30, mk(8'h03, 1, 0, 0, 8'd0, 2'd1)});
        vecs.push_back('{0, 7'h40, 7'h30, mk(8'h03, 1, 0, 0, 8'd0, 2'd1)});
        vecs.push_back('{0, 7'h40, 7'h40, mk(8'h00, 1, 0, 0, 8'd0, 2'd1)});
        vecs.push_back('{0, 7'h0E, 7'h0E, mk(8'hFF, 1, 0, 1, 8'd1, 2'd2)});
        vecs.push_back('{1, 7'h00, 7'h00, mk(8'hFF, 0, 0, 0, 8'd1, 2'd0)});
        vecs.push_back('{0, 7'h0E, 7'h0E, mk(8'hFF, 1, 0, 0, 8'd1, 2'd1)});
        vecs.push_back('{0, 7'h40, 7'h40, mk(8'h00, 1, 0, 0, 8'd1, 2'd1)});
        vecs.push_back('{0, 7'h40, 7'h40, mk(8'h00, 1, 0, 0, 8'd1, 2'd1)});
        vecs.push_back('{0, 7'h40, 7'h79, mk(8'h01, 1, 0, 0, 8'd1, 2'd1)});
        vecs.push_back('{0, 7'h40, 7'h24, mk(8'h02, 1, 0, 0, 8'd1, 2'd1)});
        vecs.push_back('{0, 7'h40, 7'h30, mk(8'h03, 1, 0, 0, 8'd1, 2'd1)});
        vecs.push_back('{0, 7'h40, 7'h19, mk(8'h04, 1, 0, 0, 8'd1, 2'd1)});
        vecs.push_back('{0, 7'h40, 7'h12, mk(8'h05, 1, 0, 0, 8'd1, 2'd1)});
        vecs.push_back('{0, 7'h40, 7'h78, mk(8'h07, 1, 0, 1, 8'd2, 2'd2)});
        vecs.push_back('{1, 7'h00, 7'h00, mk(8'h07, 0, 0, 0, 8'd2, 2'd0)});
        vecs.push_back('{0, 7'h40, 7'h7F, mk(8'h07, 0, 1, 0, 8'd3, 2'd2)});
        vecs.push_back('{0, 7'h03, 7'h46, mk(8'hBC, 1, 1, 0, 8'd3, 2'd2)});
        vecs.push_back('{0, 7'h21, 7'h06, mk(8'hDE, 1, 1, 0, 8'd3, 2'd2)});
        vecs.push_back('{0, 7'h08, 7'h10, mk(8'hA9, 1, 1, 0, 8'd3, 2'd2)});
        vecs.push_back('{0, 7'h00, 7'h02, mk(8'h86, 1, 1, 0, 8'd3, 2'd2)});

        exp_q.push_back(mk(8'h00, 0, 0, 0, 8'd0, 2'd0));
        repeat (3) @(negedge clk);
        check_out("reset");
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].is_ack) do_ack($sformatf("vec%0d_ack", i), vecs[i].e);
            else do_sample($sformatf("vec%0d", i), vecs[i].h1, vecs[i].h0, vecs[i].e);
        end

        // Ack lands on the same edge as a legal sample in ERROR.
        exp_q.push_back(mk(8'h05, 1, 0, 0, 8'd3, 2'd0));
        @(negedge clk);
        hex1 = 7'h40; hex0 = 7'h12; sample = 1'b1;
        @(negedge clk);
        sample = 1'b0;
        repeat (SYNC - 1) @(negedge clk);
        err_ack = 1'b1;
        @(negedge clk);
        err_ack = 1'b0;
        check_out("ack_priority");

        do_sample("idle_reload", 7'h40, 7'h12, mk(8'h05, 1, 0, 0, 8'd3, 2'd1));

        // Sample held high with an illegal low digit for 300 cycles.
        exp_q.push_back(mk(8'h05, 0, 1, 0, 8'hFF, 2'd2));
        @(negedge clk);
        hex1 = 7'h40; hex0 = 7'h7F; sample = 1'b1;
        repeat (300) @(negedge clk);
        sample = 1'b0;
        repeat (SYNC + 1) @(negedge clk);
        check_out("saturate");

        do_sample("load_3c", 7'h30, 7'h46, mk(8'h3C, 1, 1, 0, 8'hFF, 2'd2));

        exp_q.push_back(mk(8'h00, 0, 0, 0, 8'd0, 2'd0));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_out("async_clear");
        @(negedge clk);
        rst_n = 1'b1;

        do_sample("post_clear", 7'h40, 7'h12, mk(8'h05, 1, 0, 0, 8'd0, 2'd1));

`ifdef HEX_MON_BLANK_EN
        do_sample("blank", 7'h7F, 7'h7F, mk(8'h05, 0, 0, 0, 8'd0, 2'd1));
`else
        do_sample("blank", 7'h7F, 7'h7F, mk(8'h05, 0, 1, 0, 8'd1, 2'd2));
`endif

        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
